// File: rtl/ber_checker_lock.sv
// Counter-pattern BER checker with discard window, self-seeding reference and
// lock-loss resync. Two-stage pipeline: compare/popcount, then saturating accumulate.
module ber_checker_lock #(
  parameter int DATA_W     = 64,
  parameter int ERR_W      = 64,
  parameter int RECV_W     = 58,
  parameter int SKIP_WORDS = 1024,
  parameter int LOSS_THR   = 8
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              CLR,
  input  logic              ALIGNED,
  input  logic              DIPUSH,
  input  logic [DATA_W-1:0] DIN,
  input  logic              INIT,
  output logic              LOCKED,
  output logic [ERR_W-1:0]  ERR_CNT,
  output logic [RECV_W-1:0] RECV_CNT,
  output logic [15:0]       LOSS_CNT
);
  localparam int EW  = $clog2(DATA_W + 1);
  localparam int SKW = (SKIP_WORDS > 0) ? $clog2(SKIP_WORDS + 1) : 1;
  localparam int CW  = (LOSS_THR > 0) ? $clog2(LOSS_THR + 1) : 1;
  localparam int SW  = ((ERR_W > EW) ? ERR_W : EW) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_SEED  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [SW-1:0] ERR_MAX = {{(SW-ERR_W){1'b0}}, {ERR_W{1'b1}}};

  logic [1:0]        state;
  logic [SKW-1:0]    skip_cnt;
  logic [DATA_W-1:0] ref_word;
  logic              v1;
  logic [EW-1:0]     e1;
  logic [CW-1:0]     consec;

  logic              acc;
  logic [EW-1:0]     pop;
  logic [SW-1:0]     err_sum;
  logic [SW-1:0]     err_next;
  logic              loss_hit;

  function automatic logic [EW-1:0] popcnt(input logic [DATA_W-1:0] x);
    logic [EW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c = c + EW'(x[i]);
    return c;
  endfunction

  always_comb begin
    acc      = ALIGNED & DIPUSH;
    pop      = popcnt(DIN ^ ref_word);
    err_sum  = SW'(ERR_CNT) + SW'(e1);
    err_next = (err_sum > ERR_MAX) ? ERR_MAX : err_sum;
    loss_hit = 1'b0;
    if (LOSS_THR != 0)
      loss_hit = v1 && (e1 != '0) && (consec == CW'(LOSS_THR - 1));
  end

  assign LOCKED = (state == ST_CHECK);

  always_ff @(posedge CLK) begin
    if (!RSTX) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      ref_word <= '0;
      v1       <= 1'b0;
      e1       <= '0;
      consec   <= '0;
      ERR_CNT  <= '0;
      RECV_CNT <= '0;
      LOSS_CNT <= '0;
    end else begin
      // Stage 2: accumulate the word sitting in stage 1
      if (v1) begin
        ERR_CNT <= err_next[ERR_W-1:0];
        if (RECV_CNT != '1) RECV_CNT <= RECV_CNT + RECV_W'(1);
      end

      if (LOSS_THR != 0 && v1) begin
        if (e1 == '0)    consec <= '0;
        else if (!loss_hit) consec <= consec + CW'(1);
      end

      // Stage 1: words accepted on the resync edge are dropped, not checked
      v1 <= acc && (state == ST_CHECK) && !loss_hit;
      e1 <= pop;

      if (acc) begin
        case (state)
          ST_SKIP: begin
            if (skip_cnt != '0) skip_cnt <= skip_cnt - SKW'(1);
            else begin
              ref_word <= DIN + DATA_W'(1);
              state    <= ST_CHECK;
            end
          end
          ST_SEED: begin
            ref_word <= DIN + DATA_W'(1);
            state    <= ST_CHECK;
          end
          ST_CHECK: ref_word <= ref_word + DATA_W'(1);
          default: ;
        endcase
      end

      if (loss_hit) begin
        state  <= ST_SEED;
        consec <= '0;
        if (LOSS_CNT != '1) LOSS_CNT <= LOSS_CNT + 16'd1;
      end

      if (CLR) begin
        state    <= ST_IDLE;
        v1       <= 1'b0;
        consec   <= '0;
        ERR_CNT  <= '0;
        RECV_CNT <= '0;
        LOSS_CNT <= '0;
      end

      if (INIT) begin
        state    <= ST_SKIP;
        skip_cnt <= SKW'(SKIP_WORDS);
        v1       <= 1'b0;
        consec   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ber_checker_lock.sv
// Directed bench: one full-width instance plus an 8-bit error counter instance
// sharing the same stimulus to exercise saturation.
module tb_ber_checker_lock;
  logic        CLK = 1'b0;
  logic        RSTX, CLR, ALIGNED, DIPUSH, INIT;
  logic [63:0] DIN;

  logic        lock_a, lock_b;
  logic [63:0] err_a;
  logic [7:0]  err_b;
  logic [57:0] recv_a, recv_b;
  logic [15:0] loss_a, loss_b;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ber_checker_lock #(.DATA_W(64), .ERR_W(64), .RECV_W(58), .SKIP_WORDS(4), .LOSS_THR(8)) dut_a (
    .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .ALIGNED(ALIGNED), .DIPUSH(DIPUSH), .DIN(DIN),
    .INIT(INIT), .LOCKED(lock_a), .ERR_CNT(err_a), .RECV_CNT(recv_a), .LOSS_CNT(loss_a));

  ber_checker_lock #(.DATA_W(64), .ERR_W(8), .RECV_W(58), .SKIP_WORDS(4), .LOSS_THR(8)) dut_b (
    .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .ALIGNED(ALIGNED), .DIPUSH(DIPUSH), .DIN(DIN),
    .INIT(INIT), .LOCKED(lock_b), .ERR_CNT(err_b), .RECV_CNT(recv_b), .LOSS_CNT(loss_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    ALIGNED = 1'b1;
    DIPUSH  = 1'b1;
    DIN     = d;
    tick();
    DIPUSH  = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic lk, input logic [63:0] e,
                       input logic [63:0] r, input logic [63:0] l);
    chk({tag, "_locked"}, 64'(lock_a), 64'(lk));
    chk({tag, "_err"},    err_a, e);
    chk({tag, "_recv"},   64'(recv_a), r);
    chk({tag, "_loss"},   64'(loss_a), l);
  endtask

  initial begin
    RSTX = 1'b0; CLR = 1'b0; ALIGNED = 1'b0; DIPUSH = 1'b0; INIT = 1'b0; DIN = '0;
    tick(); tick();
    chk_a("reset", 1'b0, 0, 0, 0);
    chk("reset_err_b", 64'(err_b), 0);
    RSTX = 1'b1;

    // Discard window of 4, seed on 0x100, then 10 clean words
    INIT = 1'b1; tick(); INIT = 1'b0;
    chk("skip_locked", 64'(lock_a), 0);
    push(64'hDEAD); push(64'hBEEF); push(64'h0); push(64'h1234);
    chk("skip_end_locked", 64'(lock_a), 0);
    push(64'h100);
    chk("seed_locked", 64'(lock_a), 1);
    chk("seed_recv", 64'(recv_a), 0);
    for (int i = 1; i <= 10; i++) push(64'h100 + 64'(i));
    chk("latency_recv", 64'(recv_a), 9);
    tick();
    chk_a("clean", 1'b1, 0, 10, 0);

    // Two isolated bit-error words, then a clean one (ref now 0x10B)
    push(64'h10B ^ 64'h3);
    push(64'h10C ^ 64'h80);
    push(64'h10D);
    tick(); tick();
    chk_a("biterr", 1'b1, 3, 13, 0);
    chk("biterr_b", 64'(err_b), 3);

    // Strobe without alignment is ignored
    ALIGNED = 1'b0; DIPUSH = 1'b1; DIN = 64'h10E;
    tick(); tick(); tick();
    DIPUSH = 1'b0; ALIGNED = 1'b1;
    chk_a("unaligned", 1'b1, 3, 13, 0);

    // CLR and INIT together: counters zeroed, FSM in SKIP
    CLR = 1'b1; INIT = 1'b1; tick(); CLR = 1'b0; INIT = 1'b0;
    chk_a("clr_init", 1'b0, 0, 0, 0);
    push(64'h1); push(64'h2); push(64'h3); push(64'h4);
    push(64'h200);
    chk("reseed_locked", 64'(lock_a), 1);

    // Eight fully inverted words declare lock loss (ref 0x201)
    for (int i = 0; i < 7; i++) push(~(64'h201 + 64'(i)));
    chk("loss_pre_cnt", 64'(loss_a), 0);
    push(~(64'h208));
    chk("loss_pre_locked", 64'(lock_a), 1);
    tick();
    chk_a("loss", 1'b0, 512, 8, 1);
    chk("sat_b", 64'(err_b), 255);
    push(64'h5000);
    chk("resync_locked", 64'(lock_a), 1);
    for (int i = 1; i <= 4; i++) push(64'h5000 + 64'(i));
    tick(); tick();
    chk_a("resync_clean", 1'b1, 512, 12, 1);
    chk("sat_hold_b", 64'(err_b), 255);

    // Plain CLR returns to IDLE with counters zeroed
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk_a("clr", 1'b0, 0, 0, 0);
    chk("clr_b", 64'(err_b), 0);
    push(64'h77);
    tick(); tick();
    chk_a("idle_push", 1'b0, 0, 0, 0);

    // Reset in the middle of a measurement with ERR_CNT=5
    INIT = 1'b1; tick(); INIT = 1'b0;
    push(64'h9); push(64'h9); push(64'h9); push(64'h9);
    push(64'h300);
    push(64'h301 ^ 64'h1F);
    tick(); tick();
    chk_a("pre_rst", 1'b1, 5, 1, 0);
    RSTX = 1'b0; tick(); RSTX = 1'b1;
    chk_a("mid_rst", 1'b0, 0, 0, 0);
    chk("mid_rst_b", 64'(err_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
